ps2kb_rx: RTL and testbench
===========================

# ps2kb_rx

PS/2 keyboard receiver and scan-code queue that serves the keyboard read port of the MIO bus. It samples the PS/2 clock/data lines, deserializes and checks 11-bit frames, folds `E0`/`F0` prefixes into flag bits, and buffers complete key events in a FIFO. The CPU reads events through `ps2kb_rd`, `ps2kb_key` and `ps2_ready`. This block is the device-side end of that bus read path.

## Interface
- `FIFO_DEPTH`, 8: number of queued key events; must be a power of 2, at least 2.
- `FILT_LEN`, 4: consecutive equal `clk` samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYC`, 200000: number of `clk` cycles without a PS/2 falling edge before a partial frame is aborted.
- `clk` input 1: system clock; all logic runs on its rising edge.
- `rst` input 1: reset, asynchronous and active-low; holds the whole block in reset while 0.
- `ps2_clk` input 1: PS/2 clock pin; asynchronous to `clk`.
- `ps2_data` input 1: PS/2 data pin; asynchronous to `clk`.
- `ps2kb_rd` input 1: read strobe from the MIO bus; level signal.
- `ps2kb_key` output 10: FIFO head `{ext, brk, code[7:0]}`; reads 0 when the FIFO is empty.
- `ps2_ready` output 1: FIFO is non-empty.
- `ps2_overflow` output 1: sticky flag; an event was dropped because the FIFO was full.
- `ps2_err_cnt` output 8: saturating count of rejected frames.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
  - The filtered clock `fclk` takes the synchronized `ps2_clk` level only after `FILT_LEN` equal consecutive samples.
  - A 1→0 transition of `fclk` is the bit strobe. Data is sampled from the synchronized `ps2_data` on the strobe cycle.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP)
  - IDLE: on a strobe with data=0 (start bit), go to DATA and clear the bit count. A strobe with data=1 is ignored.
  - DATA: shift in 8 bits, LSB first, one per strobe. Go to PARITY after bit 7.
  - PARITY: capture the bit. Odd parity is required: the 8 data bits plus the parity bit contain an odd number of 1s.
  - STOP: the stop bit must be 1. Good frame → emit the byte to the decoder. Bad parity or stop=0 → discard the byte and increment `ps2_err_cnt` (saturates at 255). Both cases return to IDLE.
  - Timeout: in any state other than IDLE, if `TIMEOUT_CYC` cycles pass without a strobe, return to IDLE and increment `ps2_err_cnt`. The timeout counter reloads on every strobe.
- **Prefix decoder**
  - Byte `E0`: set `ext`. Byte `F0`: set `brk`. Neither byte is pushed.
  - Any other byte: push `{ext, brk, byte}`, then clear both flags.
  - The flags persist across frames until a non-prefix byte arrives.
- **FIFO** (show-ahead)
  - `ps2kb_key` always shows the head entry.
  - Pop occurs on the 0→1 edge of `ps2kb_rd`, detected from a registered copy of it. The bus may hold `rd` high for many cycles; that counts as exactly one pop.
  - Pop while empty: ignored.
  - Push while full: the event is dropped and `ps2_overflow` is set. `ps2_overflow` clears on the next accepted pop.
  - Push and pop in the same cycle: both take effect when not empty. When full, the pop frees the slot and the push is accepted; count is unchanged and `ps2_overflow` is not set. When empty, only the push takes effect.
  - Pointers are log2(`FIFO_DEPTH`) bits wide and wrap. The count is one bit wider.
- **Reset**: asserting `rst` at any time, including mid-frame, empties the FIFO, puts the FSM in IDLE, and clears the flags, counters and synchronizer/filter state (synchronizer and filter reset to 1).

## Timing
- Reset values:
  - `ps2kb_key`=0
  - `ps2_ready`=0
  - `ps2_overflow`=0
  - `ps2_err_cnt`=0
- Strobe latency: 2 cycles of synchronization plus `FILT_LEN` cycles after the pin's falling edge.
- Event visibility: the event is written into the FIFO in the cycle after the stop-bit strobe. `ps2_ready` and `ps2kb_key` are registered and change on the following cycle.
- Pop latency: if the `rd` rising edge is registered in cycle N, `ps2kb_key` and `ps2_ready` reflect the new head in cycle N+1.
- Glitch rejection: `ps2_clk` low pulses shorter than `FILT_LEN` cycles produce no strobe.

## Test plan
- **Single make code.** Send frame `1C`, parity 0 → `ps2_ready`=1, `ps2kb_key`=`0x01C`. Hold `rd` high for 5 cycles → exactly one pop; then `ps2_ready`=0 and `ps2kb_key`=0.
- **Extended break.** Send `E0`, `F0`, `75` → one entry, `ps2kb_key`=`0x375`. Then send `1C` → `0x01C` (flags cleared).
- **Errors.** Send a frame with a wrong parity bit, then a frame with stop=0, then 4 bits followed by silence longer than `TIMEOUT_CYC` → no entries, `ps2_err_cnt`=3. A following good `29` frame → `0x029`.
- **Overflow.** Send 9 codes `01`…`09` with no reads → `ps2_overflow`=1 and the head is `0x001`. Eight pops return `01`…`08` in order. `ps2_overflow` clears after the first pop.
- **Simultaneous push/pop at full.** FIFO full; time the `rd` edge to coincide with the push of `0A` → count stays 8, `ps2_overflow`=0, and the tail entry is `0x00A`.
- **Glitch and reset.** Inject 2-cycle low glitches on `ps2_clk` → no state change. Assert `rst` mid-frame → outputs return to 0. A full frame after release is received correctly.

Source files
------------

// File: rtl/ps2kb_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame check, E0/F0 prefix
// folding and a show-ahead key-event FIFO for the MIO keyboard read port.
module ps2kb_rx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ps2kb_rd,
    output logic [9:0] ps2kb_key,
    output logic       ps2_ready,
    output logic       ps2_overflow,
    output logic [7:0] ps2_err_cnt
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned FILT_W = $clog2(FILT_LEN + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]        clk_sync;
    logic [1:0]        data_sync;
    logic              fclk;
    logic [FILT_W-1:0] filt_cnt;
    logic              strobe;
    logic              din;

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              par_bit;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              byte_vld;
    logic [7:0]        rx_byte;

    logic              ext;
    logic              brk;
    logic [9:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              rd_q;

    logic              push_c;
    logic              pop_c;
    logic              pop_ok_c;
    logic              push_ok_c;
    logic              full_c;
    logic              empty_c;

    assign din = data_sync[1];

    // Two-flop synchronizers; idle bus level is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Clock filter: fclk follows only after FILT_LEN consecutive differing samples;
    // strobe marks the cycle after fclk falls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fclk     <= 1'b1;
            filt_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (clk_sync[1] == fclk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
                fclk     <= clk_sync[1];
                filt_cnt <= '0;
                strobe   <= ~clk_sync[1];
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end
    end

    // Frame FSM with inter-strobe timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            tmo_cnt     <= '0;
            byte_vld    <= 1'b0;
            rx_byte     <= '0;
            ps2_err_cnt <= '0;
        end else begin
            byte_vld <= 1'b0;
            if (strobe) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!din) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {din, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= din;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (din && (^{shreg, par_bit})) begin
                            byte_vld <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            ps2_err_cnt <= sat_inc(ps2_err_cnt);
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state       <= IDLE;
                    tmo_cnt     <= '0;
                    ps2_err_cnt <= sat_inc(ps2_err_cnt);
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    always_comb begin
        push_c    = byte_vld && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
        pop_c     = ps2kb_rd && !rd_q;
        empty_c   = (count == '0);
        full_c    = (count == CNT_W'(FIFO_DEPTH));
        pop_ok_c  = pop_c && !empty_c;
        push_ok_c = push_c && (!full_c || pop_ok_c);
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= {ext, brk, rx_byte};
        end
    end

    // Prefix flags, FIFO pointers and registered read-port outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext          <= 1'b0;
            brk          <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_q         <= 1'b0;
            ps2_overflow <= 1'b0;
            ps2_ready    <= 1'b0;
            ps2kb_key    <= '0;
        end else begin
            rd_q <= ps2kb_rd;
            if (byte_vld) begin
                if (rx_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok_c && !pop_ok_c) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok_c && !push_ok_c) begin
                count <= count - CNT_W'(1);
            end
            if (push_c && !push_ok_c) begin
                ps2_overflow <= 1'b1;
            end else if (pop_ok_c) begin
                ps2_overflow <= 1'b0;
            end
            ps2_ready <= !empty_c;
            ps2kb_key <= empty_c ? 10'd0 : mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_ps2kb_rx.sv
// Randomized and directed bench for ps2kb_rx: a queue-based keyboard model
// predicts every event; a monitor checks the read port at each rd rising edge.
module tb_ps2kb_rx;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 3000;
    localparam int          HALF  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ps2kb_rd = 1'b0;
    logic [9:0] ps2kb_key;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic [7:0] ps2_err_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    logic [9:0] exp_q[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_ovf = 1'b0;
    int         m_err = 0;
    logic       rd_prev = 1'b0;

    ps2kb_rx #(
        .FIFO_DEPTH (DEPTH),
        .FILT_LEN   (4),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2kb_rd    (ps2kb_rd),
        .ps2kb_key   (ps2kb_key),
        .ps2_ready   (ps2_ready),
        .ps2_overflow(ps2_overflow),
        .ps2_err_cnt (ps2_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_head();
        return (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0;
    endfunction

    // Monitor: each rd rising edge consumes the head the model predicts
    always @(negedge clk) begin
        if (ps2kb_rd && !rd_prev) begin
            chk("rd_ready", 32'(ps2_ready), 32'(exp_q.size() != 0));
            chk("rd_key", 32'(ps2kb_key), exp_head());
            chk("rd_ovf", 32'(ps2_overflow), 32'(m_ovf));
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                m_ovf = 1'b0;
            end
        end
        rd_prev = ps2kb_rd;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                             input logic bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // Drive n bits LSB first; optional 2-cycle clock glitch in each high phase,
    // optional rd rise timed to the push of this frame's event
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch,
                             input bit pop_at_stop);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (glitch) begin
                cyc(3);
                ps2_clk = 1'b0;
                cyc(2);
                ps2_clk = 1'b1;
                cyc(HALF - 5);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b0;
            if (pop_at_stop && i == 10) begin
                cyc(7);
                ps2kb_rd = 1'b1;
                cyc(HALF - 7);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        cyc(HALF / 2);
        ps2_data = 1'b1;
        cyc(HALF);
    endtask

    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            if (m_err < 255) m_err++;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
            else m_ovf = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                         input bit glitch = 0, input bit pop_at_stop = 0);
        send_bits(mk_frame(b, bad_par, bad_stop), 11, glitch, pop_at_stop);
        model_frame(b, !(bad_par || bad_stop));
    endtask

    task automatic read(input int hold);
        ps2kb_rd = 1'b1;
        cyc(hold);
        ps2kb_rd = 1'b0;
        cyc(3);
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_ready"}, 32'(ps2_ready), 32'(exp_q.size() != 0));
        chk({tag, "_key"}, 32'(ps2kb_key), exp_head());
        chk({tag, "_ovf"}, 32'(ps2_overflow), 32'(m_ovf));
        chk({tag, "_err"}, 32'(ps2_err_cnt), 32'(m_err));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         r;
        bit         bad;

        cyc(5);
        chk("reset_key", 32'(ps2kb_key), 32'd0);
        chk("reset_ready", 32'(ps2_ready), 32'd0);
        chk("reset_ovf", 32'(ps2_overflow), 32'd0);
        chk("reset_err", 32'(ps2_err_cnt), 32'd0);
        rst = 1'b1;
        cyc(5);

        // Single make code, held read pops once
        frame(8'h1C);
        chk("make_key", 32'(ps2kb_key), 32'h01C);
        chk("make_ready", 32'(ps2_ready), 32'd1);
        read(5);
        chk("after_pop_ready", 32'(ps2_ready), 32'd0);
        chk("after_pop_key", 32'(ps2kb_key), 32'd0);

        // Extended break folding
        frame(8'hE0);
        frame(8'hF0);
        frame(8'h75);
        chk("ext_brk_key", 32'(ps2kb_key), 32'h375);
        frame(8'h1C);
        check_outs("ext_brk");
        read(2);
        read(1);
        check_outs("ext_brk_drained");

        // Error frames and timeout
        frame(8'h33, 1, 0);
        frame(8'h33, 0, 1);
        send_bits(mk_frame(8'h55, 0, 0), 4, 0, 0);
        cyc(TMO + 500);
        m_err++;
        chk("err_cnt3", 32'(ps2_err_cnt), 32'd3);
        chk("err_ready", 32'(ps2_ready), 32'd0);
        frame(8'h29);
        chk("after_err_key", 32'(ps2kb_key), 32'h029);
        read(1);

        // Overflow
        for (int i = 1; i <= 9; i++) frame(8'(i));
        chk("ovf_set", 32'(ps2_overflow), 32'd1);
        chk("ovf_head", 32'(ps2kb_key), 32'h001);
        read(1);
        chk("ovf_clear", 32'(ps2_overflow), 32'd0);
        for (int i = 0; i < 7; i++) read(1);
        check_outs("ovf_drained");

        // Push and pop in the same cycle at full
        for (int i = 0; i < 8; i++) frame(8'h11 + 8'(i));
        frame(8'h0A, 0, 0, 0, 1);
        ps2kb_rd = 1'b0;
        cyc(4);
        chk("simul_ovf", 32'(ps2_overflow), 32'd0);
        check_outs("simul");
        for (int i = 0; i < 8; i++) read(1);
        check_outs("simul_drained");

        // Glitch rejection
        ps2_clk = 1'b0;
        cyc(2);
        ps2_clk = 1'b1;
        cyc(10);
        frame(8'h5A, 0, 0, 1);
        check_outs("glitch");

        // Mid-frame reset
        send_bits(mk_frame(8'h66, 0, 0), 3, 0, 0);
        rst = 1'b0;
        cyc(3);
        chk("midrst_key", 32'(ps2kb_key), 32'd0);
        chk("midrst_ready", 32'(ps2_ready), 32'd0);
        chk("midrst_ovf", 32'(ps2_overflow), 32'd0);
        chk("midrst_err", 32'(ps2_err_cnt), 32'd0);
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        m_err = 0;
        rst = 1'b1;
        cyc(5);
        frame(8'h4B);
        chk("post_rst_key", 32'(ps2kb_key), 32'h04B);
        read(1);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 5));
            b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
            bad = ($urandom_range(0, 9) == 0);
            if (bad && $urandom_range(0, 1) == 1) frame(b, 1, 0);
            else if (bad) frame(b, 0, 1);
            else frame(b);
            if ($urandom_range(0, 1) == 1) read(int'($urandom_range(1, 4)));
        end
        check_outs("rand");
        for (int i = 0; i < DEPTH + 1; i++) read(1);
        check_outs("rand_drained");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
